// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the RV32I core front end.
//   addr_t / word_t   : 32-bit address and instruction word
//   DEFAULT_RESET_PC  : default PC loaded on reset
//   fetch_state_t     : fetch FSM state encoding
//   fetch_out_t       : fetch output register (instruction word + its PC)
// Optional feature macro: RISCV_FETCH_ALIGN_CHECK_EN adds the FAULT state.
// -----------------------------------------------------------------------------
package riscv_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    localparam addr_t DEFAULT_RESET_PC = 32'h0000_0000;
    localparam addr_t PC_STEP          = 32'd4;

    typedef enum logic [2:0] {
        FETCH_REQ   = 3'd0,
        FETCH_WAIT  = 3'd1,
        FETCH_HOLD  = 3'd2,
        FETCH_DROP  = 3'd3
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        ,
        FETCH_FAULT = 3'd4
`endif
    } fetch_state_t;

    typedef struct packed {
        word_t inst;
        addr_t pc;
    } fetch_out_t;

    // Clears the two low address bits; masking keeps every input bit in use.
    function automatic addr_t word_align(input addr_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/riscv_fetch.sv
// -----------------------------------------------------------------------------
// riscv_fetch
// Instruction fetch stage: holds the PC, issues one word read at a time to
// instruction memory and hands each fetched word plus its PC to decode over a
// valid/ready handshake. Redirects from execute override the PC and squash
// anything in flight or buffered.
//
// Parameters
//   RESET_PC        PC loaded on reset (word-aligned)
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   imem_req_*      request channel to instruction memory (addr = current PC)
//   imem_rsp_*      response channel from instruction memory (no back-pressure)
//   redirect_*      PC override from execute
//   inst_valid/ready, inst, inst_pc   output to decode
//   fetch_fault     misaligned redirect target seen (align-check builds only)
//
// Optional feature macro: RISCV_FETCH_ALIGN_CHECK_EN
//   defined   : misaligned redirects park the stage in FAULT
//   undefined : redirect_pc[1:0] is forced to 2'b00; no fetch_fault port
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | request for pc offered to memory
// WAIT  | request accepted, waiting for its response
// HOLD  | instruction presented to decode; next request rides on inst_ready
// DROP  | stale request in flight, its response will be discarded
// FAULT | misaligned redirect target, fetch halted until aligned redirect
// -----------------------------------------------------------------------------
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic  clk,
    input  logic  rst,
    output logic  imem_req_valid,
    input  logic  imem_req_ready,
    output addr_t imem_req_addr,
    input  logic  imem_rsp_valid,
    input  word_t imem_rsp_data,
    input  logic  redirect_valid,
    input  addr_t redirect_pc,
    output logic  inst_valid,
    input  logic  inst_ready,
    output word_t inst,
    output addr_t inst_pc
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    ,
    output logic  fetch_fault
`endif
);

    fetch_state_t state;
    addr_t        pc;
    fetch_out_t   out_q;

    logic  req_fire;
    logic  req_outstanding;
    addr_t redirect_target;

    // Request valid is combinational so that in HOLD the next request can go
    // out in the same cycle decode takes the current instruction. It is held
    // low during reset even though the state register already reads REQ.
    always_comb begin
        imem_req_valid = 1'b0;
        if (!rst) begin
            case (state)
                FETCH_REQ:  imem_req_valid = 1'b1;
                FETCH_HOLD: imem_req_valid = inst_ready;
                default:    imem_req_valid = 1'b0;
            endcase
        end
    end

    assign imem_req_addr = pc;
    assign req_fire      = imem_req_valid && imem_req_ready;

    // A request is still owed a response after this cycle if one fires now,
    // or if we were already waiting and the response did not show up.
    assign req_outstanding = req_fire ||
                             (((state == FETCH_WAIT) || (state == FETCH_DROP)) && !imem_rsp_valid);

    assign inst    = out_q.inst;
    assign inst_pc = out_q.pc;

`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic redirect_misaligned;

    assign redirect_target     = redirect_pc;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
    // fault_q rises with the misaligned redirect itself, so it is already set
    // while a stale response is drained in DROP on the way to FAULT.
    assign fetch_fault         = fault_q;
`else
    assign redirect_target = word_align(redirect_pc);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH_REQ;
            pc         <= RESET_PC;
            inst_valid <= 1'b0;
            out_q      <= '0;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
            fault_q    <= 1'b0;
`endif
        end else if (redirect_valid) begin
            // Redirect wins in every state; any response this cycle is dropped.
            pc         <= redirect_target;
            inst_valid <= 1'b0;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
            fault_q    <= redirect_misaligned;
            if (req_outstanding) begin
                state <= FETCH_DROP;
            end else if (redirect_misaligned) begin
                state <= FETCH_FAULT;
            end else begin
                state <= FETCH_REQ;
            end
`else
            state <= req_outstanding ? FETCH_DROP : FETCH_REQ;
`endif
        end else begin
            case (state)
                FETCH_REQ: begin
                    if (req_fire) begin
                        state <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rsp_valid) begin
                        out_q.inst <= imem_rsp_data;
                        out_q.pc   <= pc;
                        pc         <= pc + PC_STEP;
                        inst_valid <= 1'b1;
                        state      <= FETCH_HOLD;
                    end
                end
                FETCH_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= req_fire ? FETCH_WAIT : FETCH_REQ;
                    end
                end
                FETCH_DROP: begin
                    if (imem_rsp_valid) begin
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
                        state <= fault_q ? FETCH_FAULT : FETCH_REQ;
`else
                        state <= FETCH_REQ;
`endif
                    end
                end
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
                FETCH_FAULT: begin
                    state <= FETCH_FAULT;
                end
`endif
                default: begin
                    state <= FETCH_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
module tb_riscv_fetch;
    import riscv_pkg::*;

    logic  clk;
    logic  rst;
    logic  imem_req_valid;
    logic  imem_req_ready;
    addr_t imem_req_addr;
    logic  imem_rsp_valid;
    word_t imem_rsp_data;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  inst_valid;
    logic  inst_ready;
    word_t inst;
    addr_t inst_pc;
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
    logic  fetch_fault;
`endif

    int checks = 0;
    int errors = 0;

    riscv_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory: a fixed hash of the address.
    function automatic word_t mem_word(input addr_t a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic  req_ready;
        logic  rsp_valid;
        word_t rsp_data;
        logic  inst_rdy;
        logic  redir_valid;
        addr_t redir_pc;
        logic  exp_req_valid;
        addr_t exp_req_addr;
        logic  exp_inst_valid;
        word_t exp_inst;
        addr_t exp_inst_pc;
    } vec_t;

    function automatic vec_t mk(input logic rr, input logic rv, input word_t rd,
                                input logic ir, input logic xv, input addr_t xpc,
                                input logic erv, input addr_t era, input logic eiv,
                                input word_t ei, input addr_t eipc);
        vec_t v;
        v.req_ready = rr;  v.rsp_valid = rv;  v.rsp_data = rd;
        v.inst_rdy = ir;   v.redir_valid = xv; v.redir_pc = xpc;
        v.exp_req_valid = erv; v.exp_req_addr = era;
        v.exp_inst_valid = eiv; v.exp_inst = ei; v.exp_inst_pc = eipc;
        return v;
    endfunction

    // Drive one cycle of inputs just after the falling edge, then settle.
    task automatic step(input logic rr, input logic rv, input word_t rd,
                        input logic ir, input logic xv, input addr_t xpc);
        @(negedge clk);
        imem_req_ready = rr;
        imem_rsp_valid = rv;
        imem_rsp_data  = rd;
        inst_ready     = ir;
        redirect_valid = xv;
        redirect_pc    = xpc;
        #1;
    endtask

    vec_t tbl [26];

    // Random-phase model state
    logic  pend;
    addr_t pend_addr;
    int    pend_dly;
    addr_t exp_i;
    addr_t exp_r;
    logic  prev_hold;
    word_t prev_inst;
    addr_t prev_pc;
    logic  prev_redir;
    int    accepted;
    addr_t target;
    logic  req_fire;

    initial begin
        word_t d0, d1, d108, d200, d204, dfc, dz;
        d0   = mem_word(32'h100);
        d1   = 32'h0050_0093;
        d108 = mem_word(32'h108);
        d200 = mem_word(32'h200);
        d204 = mem_word(32'h204);
        dfc  = mem_word(32'hFFFF_FFFC);
        dz   = mem_word(32'h0);

        //            rr rv rd    ir xv xpc            erv era            eiv ei    eipc
        tbl[0]  = mk(1, 0, 0,    1, 0, 0,             1, 32'h100,        0, 0,    0);
        tbl[1]  = mk(1, 1, d0,   1, 0, 0,             0, 32'h100,        0, 0,    0);
        tbl[2]  = mk(1, 0, 0,    1, 0, 0,             1, 32'h104,        1, d0,   32'h100);
        tbl[3]  = mk(1, 1, d1,   1, 0, 0,             0, 32'h104,        0, d0,   32'h100);
        for (int i = 4; i <= 8; i++)
            tbl[i] = mk(1, 0, 0, 0, 0, 0,             0, 32'h108,        1, d1,   32'h104);
        tbl[9]  = mk(1, 0, 0,    1, 0, 0,             1, 32'h108,        1, d1,   32'h104);
        tbl[10] = mk(1, 0, 0,    1, 0, 0,             0, 32'h108,        0, d1,   32'h104);
        tbl[11] = mk(1, 0, 0,    1, 1, 32'h200,       0, 32'h108,        0, d1,   32'h104);
        tbl[12] = mk(1, 1, d108, 1, 0, 0,             0, 32'h200,        0, d1,   32'h104);
        tbl[13] = mk(1, 0, 0,    1, 0, 0,             1, 32'h200,        0, d1,   32'h104);
        tbl[14] = mk(1, 1, d200, 1, 1, 32'h200,       0, 32'h200,        0, d1,   32'h104);
        tbl[15] = mk(0, 0, 0,    1, 0, 0,             1, 32'h200,        0, d1,   32'h104);
        tbl[16] = mk(1, 0, 0,    1, 0, 0,             1, 32'h200,        0, d1,   32'h104);
        tbl[17] = mk(1, 1, d200, 1, 0, 0,             0, 32'h200,        0, d1,   32'h104);
        tbl[18] = mk(1, 0, 0,    1, 1, 32'hFFFF_FFFC, 1, 32'h204,        1, d200, 32'h200);
        tbl[19] = mk(1, 1, d204, 1, 0, 0,             0, 32'hFFFF_FFFC,  0, d200, 32'h200);
        tbl[20] = mk(1, 0, 0,    1, 0, 0,             1, 32'hFFFF_FFFC,  0, d200, 32'h200);
        tbl[21] = mk(1, 1, dfc,  1, 0, 0,             0, 32'hFFFF_FFFC,  0, d200, 32'h200);
        tbl[22] = mk(1, 0, 0,    1, 0, 0,             1, 32'h0,          1, dfc,  32'hFFFF_FFFC);
        tbl[23] = mk(1, 1, dz,   1, 0, 0,             0, 32'h0,          0, dfc,  32'hFFFF_FFFC);
        tbl[24] = mk(0, 0, 0,    1, 0, 0,             1, 32'h4,          1, dz,   32'h0);
        tbl[25] = mk(0, 0, 0,    1, 0, 0,             1, 32'h4,          0, dz,   32'h0);

        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset state
        #1;
        check("rst_req_valid",  imem_req_valid, 0);
        check("rst_req_addr",   imem_req_addr, 32'h100);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst",       inst, 0);
        check("rst_inst_pc",    inst_pc, 0);
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        check("rst_fault",      fetch_fault, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed table: sequential fetch, back-pressure, redirects, wrap
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            imem_req_ready = tbl[i].req_ready;
            imem_rsp_valid = tbl[i].rsp_valid;
            imem_rsp_data  = tbl[i].rsp_data;
            inst_ready     = tbl[i].inst_rdy;
            redirect_valid = tbl[i].redir_valid;
            redirect_pc    = tbl[i].redir_pc;
            #1;
            check($sformatf("row%0d_req_valid", i),  imem_req_valid, tbl[i].exp_req_valid);
            check($sformatf("row%0d_req_addr", i),   imem_req_addr,  tbl[i].exp_req_addr);
            check($sformatf("row%0d_inst_valid", i), inst_valid,     tbl[i].exp_inst_valid);
            check($sformatf("row%0d_inst", i),       inst,           tbl[i].exp_inst);
            check($sformatf("row%0d_inst_pc", i),    inst_pc,        tbl[i].exp_inst_pc);
        end

        // Misaligned redirect handling (state is REQ, pc=0x4 here)
`ifdef RISCV_FETCH_ALIGN_CHECK_EN
        step(0, 0, 0, 0, 1, 32'h202);
        check("flt_pre_fault", fetch_fault, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0, 0);
            check("flt_fault",      fetch_fault, 1);
            check("flt_req_valid",  imem_req_valid, 0);
            check("flt_inst_valid", inst_valid, 0);
        end
        step(1, 0, 0, 1, 1, 32'h206);
        step(1, 0, 0, 1, 1, 32'h300);
        check("flt_again_fault", fetch_fault, 1);
        check("flt_again_addr",  imem_req_addr, 32'h206);
        check("flt_again_req",   imem_req_valid, 0);
        step(0, 0, 0, 1, 0, 0);
        check("flt_clear_fault", fetch_fault, 0);
        check("flt_clear_req",   imem_req_valid, 1);
        check("flt_clear_addr",  imem_req_addr, 32'h300);
`else
        step(0, 0, 0, 0, 1, 32'h202);
        step(0, 0, 0, 0, 0, 0);
        check("mis_req_valid", imem_req_valid, 1);
        check("mis_req_addr",  imem_req_addr, 32'h200);
`endif

        // Asynchronous reset while a request is outstanding
        step(1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 1, 0, 0);
        rst = 1'b1;
        #1;
        check("mid_rst_req_valid",  imem_req_valid, 0);
        check("mid_rst_req_addr",   imem_req_addr, 32'h100);
        check("mid_rst_inst_valid", inst_valid, 0);
        check("mid_rst_inst",       inst, 0);
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("post_rst_req_valid", imem_req_valid, 1);
        check("post_rst_req_addr",  imem_req_addr, 32'h100);

        // Randomized traffic against a stream-level reference model
        pend = 0; pend_addr = '0; pend_dly = 0;
        exp_i = 32'h100; exp_r = 32'h100;
        prev_hold = 0; prev_inst = '0; prev_pc = '0; prev_redir = 0;
        accepted = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            imem_rsp_valid = pend && (pend_dly == 0);
            imem_rsp_data  = imem_rsp_valid ? mem_word(pend_addr) : word_t'($urandom);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                target = 32'hFFFF_FFF0 + addr_t'($urandom_range(0, 3) * 4);
            else
                target = addr_t'($urandom) & 32'h0000_FFFC;
            redirect_pc = target;
            #1;

            if (prev_redir)
                check("rnd_squash", inst_valid, 0);
            if (prev_hold) begin
                check("rnd_hold_valid", inst_valid, 1);
                check("rnd_hold_inst",  inst, prev_inst);
                check("rnd_hold_pc",    inst_pc, prev_pc);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                check("rnd_inst_pc",   inst_pc, exp_i);
                check("rnd_inst_data", inst, mem_word(exp_i));
                exp_i = exp_i + 4;
                accepted++;
            end
            req_fire = imem_req_valid && imem_req_ready;
            if (req_fire) begin
                check("rnd_one_outstanding", pend, 0);
                if (!redirect_valid) begin
                    check("rnd_req_addr", imem_req_addr, exp_r);
                    exp_r = exp_r + 4;
                end
            end

            if (imem_rsp_valid) pend = 0;
            else if (pend) pend_dly--;
            if (req_fire) begin
                pend      = 1;
                pend_addr = imem_req_addr;
                pend_dly  = $urandom_range(0, 2);
            end
            if (redirect_valid) begin
                exp_i = target;
                exp_r = target;
            end
            prev_hold  = inst_valid && !inst_ready && !redirect_valid;
            prev_inst  = inst;
            prev_pc    = inst_pc;
            prev_redir = redirect_valid;
        end
        check("rnd_progress", (accepted > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
